mdu_ctrl: RTL and testbench

- Multiply/divide controller between the E-stage and the iterative mul/div unit (32-bit, valid/ready on both input and output sides).
- Decodes MDU instructions and owns the architectural HI/LO registers.
- Issues mult/div operations to the unit and drives the pipeline stall while an operation is outstanding.
- Writes unit results back into HI/LO; serves mfhi/mflo/mthi/mtlo directly.

---
 rtl/mdu_ctrl.sv | 155 +++++++++++++++
 tb/tb_mdu_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: decodes MDU ops, owns HI/LO, sequences the
// iterative mul/div unit over valid/ready and stalls E while an op is outstanding.
module mdu_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             op_valid,
  input  logic             cancel,
  input  logic [31:0]      rs,
  input  logic [31:0]      rt,
  output logic             stall,
  output logic [31:0]      rd_data,
  output logic [31:0]      u_src0,
  output logic [31:0]      u_src1,
  output logic [1:0]       u_op,
  output logic             u_sign,
  output logic             u_in_valid,
  input  logic             u_in_ready,
  input  logic             u_out_valid,
  output logic             u_out_ready,
  input  logic [31:0]      u_res0,
  input  logic [31:0]      u_res1,
  output logic [31:0]      hi,
  output logic [31:0]      lo,
  output logic [CNT_W-1:0] last_cycles
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic             act_s, is_muldiv_s, is_mdu_s, start_s, wb_s, mthi_s, mtlo_s;
  logic [1:0]       dec_op_s;
  logic             dec_sign_s;
  logic [31:0]      src0_r, src1_r, hi_r, lo_r;
  logic [1:0]       uop_r;
  logic             sign_r;
  logic [CNT_W-1:0] cnt_r, last_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Instruction decode: unit opcode/signedness and MDU class of the E-stage op.
  always_comb begin
    is_muldiv_s = 1'b0;
    is_mdu_s    = 1'b0;
    dec_op_s    = 2'b00;
    dec_sign_s  = 1'b0;
    case (op)
      4'd1:    begin is_muldiv_s = 1'b1; is_mdu_s = 1'b1; dec_op_s = 2'b01; dec_sign_s = 1'b1; end
      4'd2:    begin is_muldiv_s = 1'b1; is_mdu_s = 1'b1; dec_op_s = 2'b01; dec_sign_s = 1'b0; end
      4'd3:    begin is_muldiv_s = 1'b1; is_mdu_s = 1'b1; dec_op_s = 2'b10; dec_sign_s = 1'b1; end
      4'd4:    begin is_muldiv_s = 1'b1; is_mdu_s = 1'b1; dec_op_s = 2'b10; dec_sign_s = 1'b0; end
      4'd5, 4'd6, 4'd7, 4'd8: is_mdu_s = 1'b1;
      default: begin is_muldiv_s = 1'b0; is_mdu_s = 1'b0; end
    endcase
  end

  assign act_s   = op_valid & ~cancel;
  assign start_s = act_s & is_muldiv_s & (state_r == S_IDLE);
  assign wb_s    = (state_r == S_WAIT) & u_out_valid;
  assign mthi_s  = act_s & (op == 4'd5) & (state_r == S_IDLE);
  assign mtlo_s  = act_s & (op == 4'd6) & (state_r == S_IDLE);

  // Any MDU op waits behind an outstanding operation; the issuing op holds one cycle.
  assign stall = act_s & is_mdu_s & ((state_r != S_IDLE) | is_muldiv_s);

  // Next-state logic for the issue/wait sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: if (start_s)     state_s = S_REQ;  else state_s = S_IDLE;
      S_REQ:  if (u_in_ready)  state_s = S_WAIT; else state_s = S_REQ;
      S_WAIT: if (u_out_valid) state_s = S_IDLE; else state_s = S_WAIT;
      default: state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= state_s;
  end

  // Operand/opcode latch, held stable for the whole request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src0_r <= 32'd0;
      src1_r <= 32'd0;
      uop_r  <= 2'b00;
      sign_r <= 1'b0;
    end else if (start_s) begin
      src0_r <= rs;
      src1_r <= rt;
      uop_r  <= dec_op_s;
      sign_r <= dec_sign_s;
    end
  end

  // Architectural HI/LO: unit writeback or direct mthi/mtlo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if (wb_s) begin
      hi_r <= u_res0;
      lo_r <= u_res1;
    end else begin
      if (mthi_s) hi_r <= rs;
      if (mtlo_s) lo_r <= rs;
    end
  end

  // Issue-to-writeback latency; writeback records the count including its own cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r  <= {CNT_W{1'b0}};
      last_r <= {CNT_W{1'b0}};
    end else begin
      if (start_s)                  cnt_r <= {CNT_W{1'b0}};
      else if (state_r != S_IDLE)   cnt_r <= sat_inc(cnt_r);
      if (wb_s)                     last_r <= sat_inc(cnt_r);
    end
  end

  // HI/LO read port; no bypass from a writeback in the same cycle.
  always_comb begin
    rd_data = 32'd0;
    case (op)
      4'd7:    rd_data = hi_r;
      4'd8:    rd_data = lo_r;
      default: rd_data = 32'd0;
    endcase
  end

  assign u_src0      = src0_r;
  assign u_src1      = src1_r;
  assign u_op        = uop_r;
  assign u_sign      = sign_r;
  assign u_in_valid  = (state_r == S_REQ);
  assign u_out_ready = (state_r == S_WAIT);
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign last_cycles = last_r;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed ops, a scripted unit model, and a
// monitor that checks every issue and writeback handshake against queued expectations.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic        op_valid, cancel;
  logic [31:0] rs, rt;
  logic        stall;
  logic [31:0] rd_data, u_src0, u_src1, u_res0, u_res1, hi, lo;
  logic [1:0]  u_op;
  logic        u_sign, u_in_valid, u_in_ready, u_out_valid, u_out_ready;
  logic [7:0]  last_cycles;

  always #5 clk = ~clk;

  mdu_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid), .cancel(cancel),
    .rs(rs), .rt(rt), .stall(stall), .rd_data(rd_data),
    .u_src0(u_src0), .u_src1(u_src1), .u_op(u_op), .u_sign(u_sign),
    .u_in_valid(u_in_valid), .u_in_ready(u_in_ready),
    .u_out_valid(u_out_valid), .u_out_ready(u_out_ready),
    .u_res0(u_res0), .u_res1(u_res1), .hi(hi), .lo(lo), .last_cycles(last_cycles)
  );

  typedef struct packed { logic [1:0] uop; logic sign; logic [31:0] s0; logic [31:0] s1; } iss_t;
  typedef struct packed { logic [31:0] hi; logic [31:0] lo; logic [7:0] cyc; } wb_t;
  iss_t iss_q[$];
  wb_t  wb_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cfg_delay = 0;
  int cfg_lat = 1;
  logic [31:0] cfg_r0 = 32'd0;
  logic [31:0] cfg_r1 = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Unit model: accepts after cfg_delay cycles, returns cfg_r0/cfg_r1 cfg_lat cycles later.
  initial begin
    u_in_ready = 1'b0; u_out_valid = 1'b0; u_res0 = 32'd0; u_res1 = 32'd0;
    forever begin
      @(posedge clk); #1;
      if (u_in_valid && !reset) begin
        repeat (cfg_delay) begin @(posedge clk); #1; end
        u_in_ready = 1'b1;
        @(posedge clk); #1;
        u_in_ready = 1'b0;
        repeat (cfg_lat - 1) begin @(posedge clk); #1; end
        u_res0 = cfg_r0; u_res1 = cfg_r1; u_out_valid = 1'b1;
        @(posedge clk); #1;
        u_out_valid = 1'b0;
      end
    end
  end

  // Monitor: compares issue handshakes and post-writeback HI/LO/latency.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && u_in_valid && u_in_ready) begin
        chk("issue_expected", iss_q.size(), 32'd1);
        if (iss_q.size() > 0) begin
          iss_t e;
          e = iss_q.pop_front();
          chk("u_op", {30'd0, u_op}, {30'd0, e.uop});
          chk("u_sign", {31'd0, u_sign}, {31'd0, e.sign});
          chk("u_src0", u_src0, e.s0);
          chk("u_src1", u_src1, e.s1);
        end
      end
      if (!reset && u_out_valid && u_out_ready) begin
        @(posedge clk); #2;
        chk("wb_expected", wb_q.size(), 32'd1);
        if (wb_q.size() > 0) begin
          wb_t w;
          w = wb_q.pop_front();
          chk("wb_hi", hi, w.hi);
          chk("wb_lo", lo, w.lo);
          chk("wb_last_cycles", {24'd0, last_cycles}, {24'd0, w.cyc});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic v, input logic c,
                       input logic [31:0] a, input logic [31:0] b);
    op = o; op_valid = v; cancel = c; rs = a; rt = b;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while ((u_in_valid || u_out_ready) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_bound", {31'd0, (u_in_valid | u_out_ready)}, 32'd0);
    cyc();
  endtask

  initial begin
    int n;
    reset = 1'b1;
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) cyc();
    @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_last", {24'd0, last_cycles}, 32'd0);
    chk("rst_in_valid", {31'd0, u_in_valid}, 32'd0);
    chk("rst_out_ready", {31'd0, u_out_ready}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    // div -7 / 2, latency 10; mfhi waits behind it
    cfg_delay = 0; cfg_lat = 10; cfg_r0 = 32'hFFFFFFFF; cfg_r1 = 32'hFFFFFFFD;
    iss_q.push_back('{2'b10, 1'b1, 32'hFFFFFFF9, 32'h00000002});
    wb_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, 8'd11});
    drive(4'd3, 1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002);
    @(negedge clk); chk("div_start_stall", {31'd0, stall}, 32'd1);
    cyc(); drive(4'd7, 1'b1, 1'b0, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 11; i++) begin @(negedge clk); if (stall) n++; cyc(); end
    chk("div_stall_cycles", n, 32'd11);
    @(negedge clk);
    chk("mfhi_after_div_stall", {31'd0, stall}, 32'd0);
    chk("mfhi_after_div", rd_data, 32'hFFFFFFFF);
    cyc();

    // multu 0xFFFFFFFF * 2, then mflo stalls until writeback
    cfg_lat = 3; cfg_r0 = 32'h00000001; cfg_r1 = 32'hFFFFFFFE;
    iss_q.push_back('{2'b01, 1'b0, 32'hFFFFFFFF, 32'h00000002});
    wb_q.push_back('{32'h00000001, 32'hFFFFFFFE, 8'd4});
    drive(4'd2, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000002);
    @(negedge clk); chk("multu_start_stall", {31'd0, stall}, 32'd1);
    cyc(); drive(4'd8, 1'b1, 1'b0, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (!stall) break; n++; cyc(); end
    chk("mflo_stall_cycles", n, 32'd4);
    chk("mflo_after_multu", rd_data, 32'hFFFFFFFE);
    cyc();

    // mthi/mtlo and mfhi/mflo in IDLE; unknown op codes
    drive(4'd5, 1'b1, 1'b0, 32'h12345678, 32'd0);
    @(negedge clk);
    chk("mthi_no_stall", {31'd0, stall}, 32'd0);
    chk("mthi_no_issue", {31'd0, u_in_valid}, 32'd0);
    cyc(); drive(4'd7, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("mfhi_no_stall", {31'd0, stall}, 32'd0);
    chk("mfhi_value", rd_data, 32'h12345678);
    chk("mfhi_no_issue", {31'd0, u_in_valid | u_out_ready}, 32'd0);
    cyc(); drive(4'd6, 1'b1, 1'b0, 32'hCAFEBABE, 32'd0);
    cyc(); drive(4'd8, 1'b1, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("mflo_value", rd_data, 32'hCAFEBABE);
    chk("mtlo_keeps_hi", hi, 32'h12345678);
    cyc(); drive(4'd11, 1'b1, 1'b0, 32'h5, 32'h6);
    @(negedge clk);
    chk("op11_no_stall", {31'd0, stall}, 32'd0);
    chk("op11_rd_zero", rd_data, 32'd0);
    cyc(); drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); chk("op11_no_issue", {31'd0, u_in_valid}, 32'd0);
    cyc();

    // divu 100/7 with unit not ready for 5 cycles; bus operands change after issue
    cfg_delay = 5; cfg_lat = 2; cfg_r0 = 32'd2; cfg_r1 = 32'd14;
    iss_q.push_back('{2'b10, 1'b0, 32'd100, 32'd7});
    wb_q.push_back('{32'd2, 32'd14, 8'd8});
    drive(4'd4, 1'b1, 1'b0, 32'd100, 32'd7);
    cyc(); drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (u_in_valid && !u_in_ready && u_src0 == 32'd100 && u_src1 == 32'd7) n++;
      cyc();
    end
    chk("req_hold_cycles", n, 32'd5);
    @(negedge clk);
    chk("req_accept_valid", {31'd0, u_in_valid}, 32'd1);
    chk("req_accept_ready", {31'd0, u_in_ready}, 32'd1);
    cyc();
    @(negedge clk);
    chk("in_valid_drops", {31'd0, u_in_valid}, 32'd0);
    chk("out_ready_in_wait", {31'd0, u_out_ready}, 32'd1);
    wait_idle(20);
    cfg_delay = 0;

    // cancelled start and cancelled mthi leave state and HI/LO alone
    drive(4'd1, 1'b1, 1'b1, 32'd5, 32'd6);
    @(negedge clk); chk("cancel_no_stall", {31'd0, stall}, 32'd0);
    cyc(); drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("cancel_no_issue", {31'd0, u_in_valid}, 32'd0);
    chk("cancel_hi", hi, 32'd2);
    chk("cancel_lo", lo, 32'd14);
    cyc(); drive(4'd5, 1'b1, 1'b1, 32'hDEADBEEF, 32'd0);
    cyc(); drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); chk("cancel_mthi", hi, 32'd2);
    cyc();

    // mult -3 * 4 with flushes during WAIT: result still commits
    cfg_lat = 4; cfg_r0 = 32'hFFFFFFFF; cfg_r1 = 32'hFFFFFFF4;
    iss_q.push_back('{2'b01, 1'b1, 32'hFFFFFFFD, 32'd4});
    wb_q.push_back('{32'hFFFFFFFF, 32'hFFFFFFF4, 8'd5});
    drive(4'd1, 1'b1, 1'b0, 32'hFFFFFFFD, 32'd4);
    cyc(); drive(4'd0, 1'b1, 1'b1, 32'd0, 32'd0);
    wait_idle(20);
    drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("cancel_wait_commit_lo", lo, 32'hFFFFFFF4);

    // multu 0x10000 * 0x10000 with latency 300: counter saturates at 255
    cfg_lat = 300; cfg_r0 = 32'd1; cfg_r1 = 32'd0;
    iss_q.push_back('{2'b01, 1'b0, 32'h00010000, 32'h00010000});
    wb_q.push_back('{32'd1, 32'd0, 8'd255});
    drive(4'd2, 1'b1, 1'b0, 32'h00010000, 32'h00010000);
    cyc(); drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_idle(400);

    // async reset during WAIT; the later result pulse is ignored
    cfg_lat = 8; cfg_r0 = 32'd1; cfg_r1 = 32'd3;
    iss_q.push_back('{2'b10, 1'b1, 32'd10, 32'd3});
    drive(4'd3, 1'b1, 1'b0, 32'd10, 32'd3);
    cyc(); drive(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) cyc();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out_ready", {31'd0, u_out_ready}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    chk("async_rst_last", {24'd0, last_cycles}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (u_out_ready || u_in_valid) n++; cyc(); end
    chk("post_rst_idle_cycles_busy", n, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    chk("iss_q_drained", iss_q.size(), 32'd0);
    chk("wb_q_drained", wb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
